monopix_conf_seq: RTL and testbench

MONOPIX_CONF_SEQ -- requirements
Module: monopix_conf_seq

---
 rtl/monopix_conf_pkg.sv | 34 +++
 rtl/monopix_conf_ser.sv | 55 +++++
 rtl/monopix_conf_seq.sv | 130 +++++++++++++
 tb/tb_monopix_conf_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/monopix_conf_pkg.sv
// Shared types and constants for the MONOPIX configuration shift-register sequencer.
package monopix_conf_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SHIFT_LO,
      SHIFT_HI,
      WAIT,
      LOAD,
      FLUSH,
      FIN
   } state_t;

   localparam logic [1:0] LD_NONE = 2'd0;
   localparam logic [1:0] LD_DAC  = 2'd1;
   localparam logic [1:0] LD_PIX  = 2'd2;
   localparam logic [1:0] LD_BOTH = 2'd3;

   localparam int GLOBAL_SR_BITS = 197;
   localparam int PIX_SR_BITS    = 4644;

   // Where the sequence goes once the shifting phase is over (or skipped).
   function automatic state_t next_after_shift(input logic [7:0] wait_cyc,
                                               input logic [1:0] load_sel);
      if (wait_cyc != 8'd0)
         return WAIT;
      else if (load_sel != LD_NONE)
         return LOAD;
      else
         return FIN;
   endfunction

endpackage

// File: rtl/monopix_conf_ser.sv
// Byte serializer / readback deserializer with the bit-in-byte index.
module monopix_conf_ser (
   input  logic       SR_CLK,
   input  logic       SR_RST,
   input  logic       clear,
   input  logic       load,
   input  logic [7:0] din,
   input  logic       step,
   input  logic       so,
   input  logic       flush,
   output logic       cur_bit,
   output logic [2:0] idx,
   output logic [7:0] dout_data,
   output logic       dout_valid
);

   logic [7:0] sreg;
   logic [7:0] rreg;

   // sreg[7] is the bit that goes out in the next SHIFT_LO.
   assign cur_bit = sreg[7];

   always_ff @(posedge SR_CLK or posedge SR_RST) begin
      if (SR_RST) begin
         sreg       <= '0;
         rreg       <= '0;
         idx        <= '0;
         dout_data  <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         if (clear) begin
            rreg <= '0;
            idx  <= '0;
         end
         if (load)
            sreg <= din;
         else if (step)
            sreg <= {sreg[6:0], 1'b0};
         if (step) begin
            rreg <= {rreg[6:0], so};
            idx  <= idx + 3'd1;
            if (idx == 3'd7) begin
               dout_data  <= {rreg[6:0], so};
               dout_valid <= 1'b1;
            end
         end else if (flush && idx != 3'd0) begin
            // Partial last byte: left-align, zero LSBs.
            dout_data  <= rreg << (4'd8 - {1'b0, idx});
            dout_valid <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/monopix_conf_seq.sv
// MONOPIX configuration sequencer: streams bytes MSB-first into the chip shift
// register, collects readback bytes, then waits and pulses the load strobes.
module monopix_conf_seq
   import monopix_conf_pkg::*;
#(
   parameter int CNT_W  = 16,
   parameter int LD_LEN = 4
) (
   input  logic             SR_CLK,
   input  logic             SR_RST,
   input  logic             START,
   input  logic [CNT_W-1:0] NBITS,
   input  logic [1:0]       LOAD_SEL,
   input  logic [7:0]       WAIT_CYC,
   input  logic [7:0]       DIN_DATA,
   input  logic             DIN_VALID,
   output logic             DIN_READY,
   output logic [7:0]       DOUT_DATA,
   output logic             DOUT_VALID,
   output logic             BUSY,
   output logic             DONE,
   output logic             CONF_CLK,
   output logic             CONF_SI,
   input  logic             CONF_SO,
   output logic             CONF_LD_DAC,
   output logic             CONF_LD_PIX
);

   localparam logic [7:0] LD_LAST = 8'(LD_LEN - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] bits_left;
   logic [1:0]       sel_q, sel_eff;
   logic [7:0]       wait_q, cyc;
   logic             si_nxt, cur_bit, take, clear;
   logic [2:0]       idx;

   assign take      = (state == FETCH) && DIN_VALID;
   assign clear     = (state == IDLE) && START;
   assign sel_eff   = (state == IDLE) ? LOAD_SEL : sel_q;
   assign DIN_READY = (state == FETCH);
   assign DONE      = (state == FIN);
   assign BUSY      = (state != IDLE) && (state != FIN);

   always_comb begin
      state_nxt = state;
      si_nxt    = 1'b0;
      case (state)
         IDLE:
            if (START)
               state_nxt = (NBITS != '0) ? FETCH : next_after_shift(WAIT_CYC, LOAD_SEL);
         FETCH:
            if (DIN_VALID) begin
               state_nxt = SHIFT_LO;
               si_nxt    = DIN_DATA[7];
            end
         SHIFT_LO: begin
            state_nxt = SHIFT_HI;
            si_nxt    = CONF_SI;
         end
         SHIFT_HI:
            // idx has already advanced, so 0 here means a byte boundary.
            if (bits_left == '0)
               state_nxt = FLUSH;
            else if (idx == 3'd0)
               state_nxt = FETCH;
            else begin
               state_nxt = SHIFT_LO;
               si_nxt    = cur_bit;
            end
         FLUSH:
            state_nxt = next_after_shift(wait_q, sel_q);
         WAIT:
            if (cyc == wait_q - 8'd1)
               state_nxt = (sel_q != LD_NONE) ? LOAD : FIN;
         LOAD:
            if (cyc == LD_LAST)
               state_nxt = FIN;
         FIN:
            state_nxt = IDLE;
         default:
            state_nxt = IDLE;
      endcase
   end

   // Chip-facing pins are registered from the next state so they change cleanly on SR_CLK.
   always_ff @(posedge SR_CLK or posedge SR_RST) begin
      if (SR_RST) begin
         state       <= IDLE;
         CONF_CLK    <= 1'b0;
         CONF_SI     <= 1'b0;
         CONF_LD_DAC <= 1'b0;
         CONF_LD_PIX <= 1'b0;
         cyc         <= '0;
         bits_left   <= '0;
         sel_q       <= LD_NONE;
         wait_q      <= '0;
      end else begin
         state       <= state_nxt;
         CONF_CLK    <= (state_nxt == SHIFT_HI);
         CONF_SI     <= si_nxt;
         CONF_LD_DAC <= (state_nxt == LOAD) && (sel_eff == LD_DAC || sel_eff == LD_BOTH);
         CONF_LD_PIX <= (state_nxt == LOAD) && (sel_eff == LD_PIX || sel_eff == LD_BOTH);
         cyc         <= (state_nxt != state) ? 8'd0 : cyc + 8'd1;
         if (clear) begin
            bits_left <= NBITS;
            sel_q     <= LOAD_SEL;
            wait_q    <= WAIT_CYC;
         end else if (state == SHIFT_LO) begin
            bits_left <= bits_left - CNT_W'(1);
         end
      end
   end

   monopix_conf_ser u_ser (
      .SR_CLK     (SR_CLK),
      .SR_RST     (SR_RST),
      .clear      (clear),
      .load       (take),
      .din        (DIN_DATA),
      .step       (state == SHIFT_LO),
      .so         (CONF_SO),
      .flush      (state == FLUSH),
      .cur_bit    (cur_bit),
      .idx        (idx),
      .dout_data  (DOUT_DATA),
      .dout_valid (DOUT_VALID)
   );

endmodule

// File: tb/tb_monopix_conf_seq.sv
// Randomized bench for monopix_conf_seq against a bit-stream / byte-packing reference model.
module tb_monopix_conf_seq;
   import monopix_conf_pkg::*;

   localparam int CNT_W  = 16;
   localparam int LD_LEN = 4;

   logic             sr_clk = 1'b0;
   logic             sr_rst = 1'b1;
   logic             start = 1'b0;
   logic [CNT_W-1:0] nbits = '0;
   logic [1:0]       load_sel = '0;
   logic [7:0]       wait_cyc = '0;
   logic [7:0]       din_data = '0;
   logic             din_valid = 1'b0;
   logic             din_ready, dout_valid, busy, done;
   logic [7:0]       dout_data;
   logic             conf_clk, conf_si, conf_so, conf_ld_dac, conf_ld_pix;

   int total = 0;
   int bad   = 0;

   logic [7:0] din_bytes [0:1023];
   bit         so_bits   [0:8191];
   bit         so_loop = 1'b1;

   int  tb_cyc = 0, pulses = 0, done_cnt = 0, din_cnt = 0, dac_hi = 0, pix_hi = 0;
   int  hold_err = 0, stall_err = 0, busy_err = 0, last_hi = 0, busy_rise = 0, ld_rise = -1;
   bit  clk_prev = 1'b0, si_prev = 1'b0, busy_prev = 1'b0, ld_prev = 1'b0;
   bit         si_obs[$];
   logic [7:0] dout_obs[$];

   monopix_conf_seq #(.CNT_W(CNT_W), .LD_LEN(LD_LEN)) dut (
      .SR_CLK      (sr_clk),
      .SR_RST      (sr_rst),
      .START       (start),
      .NBITS       (nbits),
      .LOAD_SEL    (load_sel),
      .WAIT_CYC    (wait_cyc),
      .DIN_DATA    (din_data),
      .DIN_VALID   (din_valid),
      .DIN_READY   (din_ready),
      .DOUT_DATA   (dout_data),
      .DOUT_VALID  (dout_valid),
      .BUSY        (busy),
      .DONE        (done),
      .CONF_CLK    (conf_clk),
      .CONF_SI     (conf_si),
      .CONF_SO     (conf_so),
      .CONF_LD_DAC (conf_ld_dac),
      .CONF_LD_PIX (conf_ld_pix)
   );

   always #5 sr_clk = ~sr_clk;

   // Chip model: either a loopback wire or a random readback bit per clock pulse.
   assign conf_so = so_loop ? conf_si : so_bits[pulses < 8192 ? pulses : 0];

   always @(negedge sr_clk) begin
      tb_cyc++;
      if (conf_clk && !clk_prev) begin
         si_obs.push_back(conf_si);
         last_hi = tb_cyc;
      end
      if (conf_clk && conf_si !== si_prev) hold_err++;
      if (din_ready && conf_clk) stall_err++;
      if (din_ready && din_valid) din_cnt++;
      if (dout_valid) dout_obs.push_back(dout_data);
      if (done) begin
         done_cnt++;
         if (busy) busy_err++;
      end
      if (busy && !busy_prev) busy_rise = tb_cyc;
      if (conf_ld_dac) dac_hi++;
      if (conf_ld_pix) pix_hi++;
      if ((conf_ld_dac || conf_ld_pix) && !ld_prev) ld_rise = tb_cyc;
      clk_prev  = conf_clk;
      si_prev   = conf_si;
      busy_prev = busy;
      ld_prev   = conf_ld_dac || conf_ld_pix;
      pulses    = si_obs.size();
   end

   task automatic check(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      si_obs.delete();
      dout_obs.delete();
      done_cnt = 0; din_cnt = 0; dac_hi = 0; pix_hi = 0;
      hold_err = 0; stall_err = 0; busy_err = 0; ld_rise = -1; pulses = 0;
   endtask

   function automatic bit exp_si(input int k);
      logic [7:0] b;
      b = din_bytes[k / 8];
      return b[7 - (k % 8)];
   endfunction

   // mode: 0 random bytes, 1 ramp 0,1,2..., 2 all 0xA5
   task automatic run_xfer(input string name, input int nb, input logic [1:0] sel,
                           input logic [7:0] wc, input int stall_byte, input int stall_len,
                           input bit loop, input int mode, input bit restart);
      int nbytes, fed, stalled, budget, errs, ld_exp;
      bit hs;
      logic [7:0] v;
      nbytes = (nb + 7) / 8;
      for (int i = 0; i < nbytes; i++)
         din_bytes[i] = (mode == 1) ? 8'(i) : (mode == 2) ? 8'hA5 : 8'($urandom);
      for (int i = 0; i < nb; i++) so_bits[i] = 1'($urandom);
      so_loop = loop;
      clear_mon();
      @(posedge sr_clk); #1;
      start = 1'b1; nbits = CNT_W'(nb); load_sel = sel; wait_cyc = wc;
      fed = 0; stalled = 0;
      budget = 4 * nb + 2 * int'(wc) + stall_len + 60;
      for (int c = 0; c < budget && done_cnt == 0; c++) begin
         @(posedge sr_clk); #1;
         start = restart && (c == 3);
         if (start) begin
            nbits = CNT_W'(5); load_sel = LD_BOTH;
         end
         din_valid = (fed < nbytes) && !(fed == stall_byte && stalled < stall_len);
         if (fed < nbytes) din_data = din_bytes[fed];
         @(negedge sr_clk);
         hs = din_ready && din_valid;
         if (din_ready && !din_valid && fed == stall_byte) stalled++;
         if (hs) fed++;
      end
      din_valid = 1'b0;
      start = 1'b0;
      repeat (6) @(posedge sr_clk);
      #1;
      check({name, ":done_once"}, done_cnt, 1);
      check({name, ":busy_low_at_done"}, busy_err, 0);
      check({name, ":busy_after"}, busy, 0);
      check({name, ":din_bytes"}, din_cnt, nbytes);
      check({name, ":clk_pulses"}, si_obs.size(), nb);
      errs = 0;
      for (int k = 0; k < nb && k < si_obs.size(); k++)
         if (si_obs[k] != exp_si(k)) errs++;
      check({name, ":si_bit_errors"}, errs, 0);
      check({name, ":si_hold_errors"}, hold_err, 0);
      check({name, ":clk_during_fetch"}, stall_err, 0);
      if (stall_len > 0 && stall_byte < nbytes)
         check({name, ":stall_cycles"}, stalled, stall_len);
      check({name, ":dout_count"}, dout_obs.size(), nbytes);
      for (int j = 0; j < nbytes && j < dout_obs.size(); j++) begin
         v = 8'h00;
         for (int k = 0; k < 8; k++)
            if (8 * j + k < nb) v[7 - k] = loop ? exp_si(8 * j + k) : so_bits[8 * j + k];
         check($sformatf("%s:dout[%0d]", name, j), dout_obs[j], v);
      end
      check({name, ":ld_dac_cycles"}, dac_hi, (sel == LD_DAC || sel == LD_BOTH) ? LD_LEN : 0);
      check({name, ":ld_pix_cycles"}, pix_hi, (sel == LD_PIX || sel == LD_BOTH) ? LD_LEN : 0);
      if (sel != LD_NONE) begin
         ld_exp = (nb > 0) ? last_hi + 2 + int'(wc) : busy_rise + int'(wc);
         check({name, ":ld_rise_cycle"}, ld_rise, ld_exp);
      end
   endtask

   task automatic check_reset_values(input string name);
      check({name, ":conf_clk"}, conf_clk, 0);
      check({name, ":conf_si"}, conf_si, 0);
      check({name, ":ld_dac"}, conf_ld_dac, 0);
      check({name, ":ld_pix"}, conf_ld_pix, 0);
      check({name, ":din_ready"}, din_ready, 0);
      check({name, ":dout_valid"}, dout_valid, 0);
      check({name, ":dout_data"}, dout_data, 0);
      check({name, ":busy"}, busy, 0);
      check({name, ":done"}, done, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int nb, nbytes;
      repeat (3) @(posedge sr_clk);
      #1;
      check_reset_values("por");
      sr_rst = 1'b0;

      run_xfer("a5_dac", 8, LD_DAC, 8'd0, -1, 0, 1'b1, 2, 1'b0);
      if (dout_obs.size() > 0) check("a5_dac:dout_is_a5", dout_obs[0], 8'hA5);

      run_xfer("global", GLOBAL_SR_BITS, LD_DAC, 8'd0, -1, 0, 1'b1, 1, 1'b0);
      if (dout_obs.size() > 0) check("global:last_lsbs", dout_obs[$] & 8'h07, 0);

      run_xfer("stall12", 12, LD_NONE, 8'd0, 1, 10, 1'b1, 0, 1'b0);
      run_xfer("nbits0_pix", 0, LD_PIX, 8'd3, -1, 0, 1'b1, 0, 1'b1);

      for (int it = 0; it < 8; it++) begin
         nb = $urandom_range(1, 40);
         nbytes = (nb + 7) / 8;
         run_xfer($sformatf("rand%0d", it), nb, 2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 6)), $urandom_range(0, nbytes - 1),
                  $urandom_range(0, 5), 1'($urandom), 0, 1'b0);
      end

      // Reset in the middle of a long pixel-register transfer.
      clear_mon();
      so_loop = 1'b1;
      @(posedge sr_clk); #1;
      start = 1'b1; nbits = CNT_W'(PIX_SR_BITS); load_sel = LD_PIX; wait_cyc = 8'd0;
      din_valid = 1'b1; din_data = 8'($urandom);
      @(posedge sr_clk); #1;
      start = 1'b0;
      for (int c = 0; c < 400 && pulses < 21; c++) begin
         @(negedge sr_clk); #1;
         din_data = 8'($urandom);
      end
      check("midrst:reached_bit20", pulses, 21);
      sr_rst = 1'b1;
      #1;
      check_reset_values("midrst");
      @(posedge sr_clk); #1;
      din_valid = 1'b0;
      sr_rst = 1'b0;
      run_xfer("after_rst", 8, LD_DAC, 8'd2, -1, 0, 1'b0, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
